// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: carries the executed instruction into the MEM stage,
// produces the one-cycle beq redirect pulse and keeps saturating flush/retire counters.
module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] store_data,
  input  logic [RD_W-1:0]   rd,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              branch,
  input  logic [DATA_W-1:0] branch_target,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_alu_f,
  output logic [DATA_W-1:0] out_store_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              branch_taken,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  flush_count,
  output logic [CNT_W-1:0]  retire_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic load;
  logic ctrl_ok;

  assign load = !flush && !stall;
  // Controls only pass for a real, non-branch instruction.
  assign ctrl_ok = in_valid && !branch;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid      <= 1'b0;
      out_alu_f      <= '0;
      out_store_data <= '0;
      out_rd         <= '0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      redirect_pc    <= '0;
    end else if (load) begin
      out_valid      <= in_valid;
      out_alu_f      <= alu_f;
      out_store_data <= store_data;
      out_rd         <= rd;
      out_reg_write  <= ctrl_ok && reg_write;
      out_mem_read   <= ctrl_ok && mem_read;
      out_mem_write  <= ctrl_ok && mem_write;
      redirect_pc    <= branch_target;
    end
  end

  // The redirect pulse is never held: a stalled taken branch has already redirected.
  always_ff @(posedge clk) begin
    if (rst || !load) begin
      branch_taken <= 1'b0;
    end else begin
      branch_taken <= in_valid && branch && alu_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_count  <= '0;
      retire_count <= '0;
    end else begin
      if (flush && flush_count != CNT_MAX) begin
        flush_count <= flush_count + 1'b1;
      end
      if (load && in_valid && retire_count != CNT_MAX) begin
        retire_count <= retire_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized bench for ex_mem_reg: a per-instruction reference model predicts the MEM
// stage contents; a second CNT_W=4 instance exercises counter saturation.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, alu_zero;
  logic        reg_write, mem_read, mem_write, branch;
  logic [31:0] alu_f, store_data, branch_target;
  logic [4:0]  rd;

  logic        out_valid, out_reg_write, out_mem_read, out_mem_write, branch_taken;
  logic [31:0] out_alu_f, out_store_data, redirect_pc;
  logic [4:0]  out_rd;
  logic [15:0] flush_count, retire_count;

  logic        s_valid, s_reg_write, s_mem_read, s_mem_write, s_branch_taken;
  logic [31:0] s_alu_f, s_store_data, s_redirect_pc;
  logic [4:0]  s_rd;
  logic [3:0]  s_flush_count, s_retire_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the MEM stage should be holding right now.
  logic        m_valid, m_rw, m_mr, m_mw, m_taken;
  logic [31:0] m_alu, m_store, m_redirect;
  logic [4:0]  m_rd;
  int          m_flush, m_retire, m_small_flush, m_small_retire;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_f(alu_f), .alu_zero(alu_zero), .store_data(store_data), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .branch_target(branch_target), .out_valid(out_valid), .out_alu_f(out_alu_f),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .branch_taken(branch_taken), .redirect_pc(redirect_pc),
    .flush_count(flush_count), .retire_count(retire_count)
  );

  ex_mem_reg #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_f(alu_f), .alu_zero(alu_zero), .store_data(store_data), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .branch_target(branch_target), .out_valid(s_valid), .out_alu_f(s_alu_f),
    .out_store_data(s_store_data), .out_rd(s_rd), .out_reg_write(s_reg_write),
    .out_mem_read(s_mem_read), .out_mem_write(s_mem_write),
    .branch_taken(s_branch_taken), .redirect_pc(s_redirect_pc),
    .flush_count(s_flush_count), .retire_count(s_retire_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic clearInputs();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_zero = 1'b0;
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0;
    alu_f = '0; store_data = '0; branch_target = '0; rd = '0;
  endtask

  function automatic int satInc(input int value, input int limit);
    return (value < limit) ? value + 1 : value;
  endfunction

  // Advance the model by one edge using the instruction currently presented by EX.
  task automatic updateModel();
    if (rst) begin
      {m_valid, m_rw, m_mr, m_mw, m_taken} = '0;
      m_alu = '0; m_store = '0; m_redirect = '0; m_rd = '0;
      m_flush = 0; m_retire = 0; m_small_flush = 0; m_small_retire = 0;
    end else if (flush) begin
      {m_valid, m_rw, m_mr, m_mw, m_taken} = '0;
      m_alu = '0; m_store = '0; m_redirect = '0; m_rd = '0;
      m_flush       = satInc(m_flush, 65535);
      m_small_flush = satInc(m_small_flush, 15);
    end else if (stall) begin
      m_taken = 1'b0;
    end else begin
      m_valid    = in_valid;
      m_alu      = alu_f;
      m_store    = store_data;
      m_rd       = rd;
      m_redirect = branch_target;
      m_rw       = in_valid && !branch && reg_write;
      m_mr       = in_valid && !branch && mem_read;
      m_mw       = in_valid && !branch && mem_write;
      m_taken    = in_valid && branch && alu_zero;
      if (in_valid) begin
        m_retire       = satInc(m_retire, 65535);
        m_small_retire = satInc(m_small_retire, 15);
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid", 64'(out_valid), 64'(m_valid));
    checkOutput("out_alu_f", 64'(out_alu_f), 64'(m_alu));
    checkOutput("out_store_data", 64'(out_store_data), 64'(m_store));
    checkOutput("out_rd", 64'(out_rd), 64'(m_rd));
    checkOutput("out_reg_write", 64'(out_reg_write), 64'(m_rw));
    checkOutput("out_mem_read", 64'(out_mem_read), 64'(m_mr));
    checkOutput("out_mem_write", 64'(out_mem_write), 64'(m_mw));
    checkOutput("branch_taken", 64'(branch_taken), 64'(m_taken));
    checkOutput("redirect_pc", 64'(redirect_pc), 64'(m_redirect));
    checkOutput("flush_count", 64'(flush_count), 64'(m_flush));
    checkOutput("retire_count", 64'(retire_count), 64'(m_retire));
    checkOutput("small_valid", 64'(s_valid), 64'(m_valid));
    checkOutput("small_taken", 64'(s_branch_taken), 64'(m_taken));
    checkOutput("small_flush_count", 64'(s_flush_count), 64'(m_small_flush));
    checkOutput("small_retire_count", 64'(s_retire_count), 64'(m_small_retire));
  endtask

  task automatic applyStimulus();
    updateModel();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic randomInputs();
    rst           = ($urandom_range(0, 39) == 0);
    flush         = ($urandom_range(0, 7) == 0);
    stall         = ($urandom_range(0, 4) == 0);
    in_valid      = ($urandom_range(0, 3) != 0);
    branch        = ($urandom_range(0, 3) == 0);
    alu_zero      = 1'($urandom_range(0, 1));
    reg_write     = 1'($urandom_range(0, 1));
    mem_read      = 1'($urandom_range(0, 1));
    mem_write     = 1'($urandom_range(0, 1));
    alu_f         = $urandom();
    store_data    = $urandom();
    branch_target = $urandom();
    rd            = 5'($urandom_range(0, 31));
  endtask

  initial begin
    clearInputs();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_taken = 0;
    m_alu = 0; m_store = 0; m_redirect = 0; m_rd = 0;
    m_flush = 0; m_retire = 0; m_small_flush = 0; m_small_retire = 0;
    @(negedge clk);

    // Held reset ignores a valid instruction on the inputs.
    rst = 1'b1; in_valid = 1'b1; reg_write = 1'b1; alu_f = 32'hdead_beef; rd = 5'd9;
    applyStimulus();
    applyStimulus();
    clearInputs();

    // Simple ALU instruction.
    in_valid = 1'b1; alu_f = 32'h0000_0010; rd = 5'd5; reg_write = 1'b1;
    applyStimulus();
    checkOutput("load_alu_f_const", 64'(out_alu_f), 64'h10);
    checkOutput("load_retire_const", 64'(retire_count), 64'd1);

    // Taken beq followed by two stalls: pulse only in the first cycle.
    clearInputs();
    in_valid = 1'b1; branch = 1'b1; alu_zero = 1'b1; reg_write = 1'b1;
    mem_write = 1'b1; branch_target = 32'h40;
    applyStimulus();
    checkOutput("beq_pulse_const", 64'(branch_taken), 64'd1);
    stall = 1'b1;
    applyStimulus();
    checkOutput("beq_stall1_const", 64'(branch_taken), 64'd0);
    applyStimulus();
    checkOutput("beq_hold_pc_const", 64'(redirect_pc), 64'h40);
    checkOutput("beq_retire_const", 64'(retire_count), 64'd2);

    // Not-taken beq.
    stall = 1'b0; alu_zero = 1'b0;
    applyStimulus();

    // Flush wins over stall with a valid store waiting.
    clearInputs();
    in_valid = 1'b1; mem_write = 1'b1; alu_f = 32'h1234; store_data = 32'h55;
    flush = 1'b1; stall = 1'b1;
    applyStimulus();
    checkOutput("flush_count_const", 64'(flush_count), 64'd1);

    // Taken branch then reset on the next edge.
    clearInputs();
    in_valid = 1'b1; branch = 1'b1; alu_zero = 1'b1; branch_target = 32'h80;
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    checkOutput("rst_kills_pulse_const", 64'(branch_taken), 64'd0);

    // Seventeen flushes saturate the narrow counter.
    clearInputs();
    flush = 1'b1;
    for (int i = 0; i < 17; i++) applyStimulus();
    checkOutput("small_flush_sat_const", 64'(s_flush_count), 64'hf);
    checkOutput("wide_flush_17_const", 64'(flush_count), 64'd17);

    for (int i = 0; i < 600; i++) begin
      randomInputs();
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
